// File: rtl/instr_fetch.sv
// Instruction fetch stage: 256x16 program memory with a load port and a
// fetch FSM that presents one word at a time to decode with valid/ready.
module instr_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pc,
   input  logic        fetch_req,
   input  logic        flush,
   input  logic        load_en,
   input  logic [7:0]  load_addr,
   input  logic [15:0] load_data,
   output logic [15:0] instr,
   output logic [7:0]  instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        busy,
   output logic        load_err
);

   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t          state;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   mem [DEPTH];

   // Program memory: writable only while idle, deliberately not reset.
   always_ff @(posedge clk) begin
      if (load_en && state == IDLE) begin
         mem[load_addr] <= load_data;
      end
   end

   // Fetch FSM; busy is kept as a register that tracks state != IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         addr_q      <= '0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         busy        <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         if (load_en && state != IDLE) begin
            load_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (!load_en && fetch_req) begin
                  addr_q <= pc;
                  state  <= READ;
                  busy   <= 1'b1;
               end
            end
            READ: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  instr       <= mem[addr_q];
                  instr_pc    <= addr_q;
                  instr_valid <= 1'b1;
                  state       <= VALID;
               end
            end
            VALID: begin
               // Flush wins over a handshake or a chained request.
               if (flush) begin
                  instr_valid <= 1'b0;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  if (fetch_req) begin
                     addr_q <= pc;
                     state  <= READ;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               instr_valid <= 1'b0;
               state       <= IDLE;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scoreboard bench for instr_fetch.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pc;
   logic        fetch_req;
   logic        flush;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [15:0] load_data;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        busy;
   logic        load_err;

   instr_fetch dut (
      .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .flush(flush),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .busy(busy), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] w;
      logic [7:0]  a;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem_m [256];
   int          vectors = 0;
   int          miscompares = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] a, input logic [15:0] d);
      load_addr = a;
      load_data = d;
      load_en   = 1'b1;
      step();
      load_en   = 1'b0;
      mem_m[a]  = d;
   endtask

   task automatic push(input logic [7:0] a);
      sb.push_back({mem_m[a], a});
   endtask

   // Compare the presented word against the oldest expected fetch.
   task automatic expect_out(input string tag);
      exp_t e;
      chk({tag, "_valid"}, 16'(instr_valid), 16'h0001);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 16'h0001, 16'h0000);
      end else begin
         e = sb.pop_front();
         chk({tag, "_instr"}, instr, e.w);
         chk({tag, "_pc"}, 16'(instr_pc), 16'(e.a));
      end
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int n = 0;
      while (!instr_valid && n < limit) begin
         step();
         n++;
      end
      if (!instr_valid) chk({tag, "_timeout"}, 16'(n), 16'(limit + 1));
   endtask

   logic [15:0] hold_w;
   logic [7:0]  hold_a;
   logic        pat [7];
   int          idx;

   initial begin
      rst = 1'b1; pc = '0; fetch_req = 1'b0; flush = 1'b0;
      load_en = 1'b0; load_addr = '0; load_data = '0; instr_ready = 1'b0;
      step();
      step();
      chk("rst_instr", instr, 16'h0000);
      chk("rst_pc", 16'(instr_pc), 16'h0000);
      chk("rst_valid", 16'(instr_valid), 16'h0000);
      chk("rst_busy", 16'(busy), 16'h0000);
      chk("rst_lerr", 16'(load_err), 16'h0000);
      rst = 1'b0;
      step();

      // Program load, including the top address.
      load(8'h10, 16'hA5C3);
      load(8'h00, 16'h1111);
      load(8'h01, 16'h2222);
      load(8'h02, 16'h3333);
      load(8'h20, 16'hDEAD);
      load(8'h40, 16'hBEEF);
      load(8'h05, 16'h0505);
      load(8'hFF, 16'hFFEE);

      // Load has priority over a same-cycle fetch.
      fetch_req = 1'b1; pc = 8'h10;
      load(8'h03, 16'h4444);
      fetch_req = 1'b0;
      chk("ldprio_busy", 16'(busy), 16'h0000);

      // Load then fetch, two-edge latency.
      instr_ready = 1'b1; pc = 8'h10; fetch_req = 1'b1; push(8'h10);
      step();
      fetch_req = 1'b0;
      chk("lf_valid_n1", 16'(instr_valid), 16'h0000);
      chk("lf_busy_n1", 16'(busy), 16'h0001);
      step();
      expect_out("lf");
      step();
      chk("lf_idle_valid", 16'(instr_valid), 16'h0000);
      chk("lf_idle_busy", 16'(busy), 16'h0000);

      // Backpressure: five stalled cycles, then exactly one acceptance.
      instr_ready = 1'b0; pc = 8'h00; fetch_req = 1'b1; push(8'h00);
      step();
      fetch_req = 1'b0;
      step();
      hold_w = instr; hold_a = instr_pc;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", 16'(instr_valid), 16'h0001);
         chk("bp_instr", instr, hold_w);
         chk("bp_pc", 16'(instr_pc), 16'(hold_a));
      end
      instr_ready = 1'b1;
      expect_out("bp");
      step();
      chk("bp_once", 16'(instr_valid), 16'h0000);

      // Back-to-back at pc 0,1,2.
      pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
      pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;
      pc = 8'h00; fetch_req = 1'b1; push(8'h00); idx = 1;
      for (int i = 0; i < 7; i++) begin
         chk("b2b_pat", 16'(instr_valid), 16'(pat[i]));
         if (instr_valid) begin
            expect_out("b2b");
            if (idx < 3) begin
               pc = 8'(idx); push(8'(idx)); idx++;
            end else begin
               fetch_req = 1'b0;
            end
         end
         step();
      end
      chk("b2b_end_busy", 16'(busy), 16'h0000);

      // Flush in READ: word at 8'h20 never appears.
      pc = 8'h20; fetch_req = 1'b1;
      step();
      fetch_req = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("fl_read_valid", 16'(instr_valid), 16'h0000);
         chk("fl_read_busy", 16'(busy), 16'h0000);
         step();
      end

      // Flush in IDLE is ignored and the fetch is taken.
      flush = 1'b1; pc = 8'h40; fetch_req = 1'b1; push(8'h40);
      step();
      flush = 1'b0; fetch_req = 1'b0;
      chk("fl_idle_busy", 16'(busy), 16'h0001);
      step();
      expect_out("fl_new");
      step();

      // Flush in VALID overrides ready and a chained request.
      pc = 8'h02; fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      step();
      chk("fl_valid_pre", instr, 16'h3333);
      flush = 1'b1; fetch_req = 1'b1; pc = 8'h01;
      step();
      flush = 1'b0; fetch_req = 1'b0;
      chk("fl_valid_v", 16'(instr_valid), 16'h0000);
      chk("fl_valid_busy", 16'(busy), 16'h0000);
      step();

      // Load while busy is dropped and sets the sticky error.
      instr_ready = 1'b0; pc = 8'h10; fetch_req = 1'b1; push(8'h10);
      step();
      fetch_req = 1'b0;
      step();
      load_addr = 8'h05; load_data = 16'hCAFE; load_en = 1'b1;
      step();
      load_en = 1'b0;
      chk("lb_err", 16'(load_err), 16'h0001);
      instr_ready = 1'b1;
      expect_out("lb_hold");
      step();
      pc = 8'h05; fetch_req = 1'b1; push(8'h05);
      step();
      fetch_req = 1'b0;
      step();
      expect_out("lb_mem05");
      chk("lb_err_sticky", 16'(load_err), 16'h0001);
      step();

      // Address 255 is ordinary.
      pc = 8'hFF; fetch_req = 1'b1; push(8'hFF);
      step();
      fetch_req = 1'b0;
      step();
      expect_out("a255");
      step();

      // Async reset mid-cycle in VALID.
      instr_ready = 1'b0; pc = 8'h01; fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      step();
      chk("ar_pre_valid", 16'(instr_valid), 16'h0001);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 16'(instr_valid), 16'h0000);
      chk("ar_busy", 16'(busy), 16'h0000);
      chk("ar_instr", instr, 16'h0000);
      chk("ar_pc", 16'(instr_pc), 16'h0000);
      chk("ar_lerr", 16'(load_err), 16'h0000);
      step();
      rst = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ar_no_pulse", 16'(instr_valid), 16'h0000);
      end
      pc = 8'h10; fetch_req = 1'b1; push(8'h10);
      step();
      fetch_req = 1'b0;
      wait_valid("ar_mem", 4);
      expect_out("ar_mem");
      step();

      chk("sb_drained", 16'(sb.size()), 16'h0000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
